// File: rtl/dev_bus_pkg.sv
// Shared types and device address map for the two-master device-bus arbiter.
package dev_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam int unsigned CNT_W = 4;

    localparam logic [31:0] DEV_BASE  = 32'h0000_7F00;
    localparam logic [31:0] DEV_LIMIT = 32'h0000_7F2F;

    localparam logic [31:0] TC_BASE  = 32'h0000_7F00;
    localparam logic [31:0] OUT_BASE = 32'h0000_7F10;
    localparam logic [31:0] IN_BASE  = 32'h0000_7F20;

    // Inclusive window check; bounds default to the fixed map but the top passes its parameters.
    function automatic logic dev_hit(input logic [31:0] addr,
                                     input logic [31:0] base  = DEV_BASE,
                                     input logic [31:0] limit = DEV_LIMIT);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/dev_bus_arbiter_rr_pick2.sv
// Two-way winner selection. Round-robin on ties by default; with ARB_FIXED_PRIO_EN defined
// master 0 always wins a tie and last is ignored.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       idx
);

`ifdef ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        valid = |req;
        idx   = ~req[0] & req[1];
    end
`else
    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            idx = ~last;
        end else begin
            idx = req[1];
        end
    end
`endif

endmodule

// File: rtl/dev_bus_arbiter.sv
// Two-master device-bus arbiter and sequencer (IDLE -> ACCESS -> RESP) with wait states,
// single-pulse writes and miss reporting. Tie policy set by ARB_FIXED_PRIO_EN in rr_pick2.
module dev_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] DEV_BASE    = dev_bus_pkg::DEV_BASE,
    parameter logic [31:0] DEV_LIMIT   = dev_bus_pkg::DEV_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic [31:0] br_addr,
    output logic [31:0] br_wdata,
    output logic        br_we,
    input  logic [31:0] br_rdata,

    output logic        busy,
    output logic        owner
);
    import dev_bus_pkg::*;

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    arb_state_e       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             hit_q, hit_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             pick_valid;
    logic             pick_idx;

    rr_pick2 u_pick (
        .req   ({m1_req, m0_req}),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // NOTE: every output and next-state signal gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        hit_d    = hit_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        br_addr  = '0;
        br_wdata = '0;
        br_we    = 1'b0;
        m0_ack   = 1'b0;
        m0_rdata = '0;
        m0_err   = 1'b0;
        m1_ack   = 1'b0;
        m1_rdata = '0;
        m1_err   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    addr_d  = pick_idx ? m1_addr  : m0_addr;
                    wdata_d = pick_idx ? m1_wdata : m0_wdata;
                    we_d    = pick_idx ? m1_we    : m0_we;
                    hit_d   = dev_hit(pick_idx ? m1_addr : m0_addr, DEV_BASE, DEV_LIMIT);
                    cnt_d   = WAIT_INIT;
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                br_addr  = addr_q;
                br_wdata = wdata_q;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Last access cycle: the only cycle a write strobe may reach the bridge.
                    br_we   = we_q & hit_q;
                    rdata_d = hit_q ? br_rdata : '0;
                    err_d   = ~hit_q;
                    state_d = RESP;
                end
            end

            RESP: begin
                if (owner_q) begin
                    m1_ack   = 1'b1;
                    m1_rdata = rdata_q;
                    m1_err   = err_q;
                end else begin
                    m0_ack   = 1'b1;
                    m0_rdata = rdata_q;
                    m0_err   = err_q;
                end
                last_d  = owner_q;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        busy  = (state_q != IDLE);
        owner = busy ? owner_q : 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            hit_q   <= hit_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Self-checking bench for dev_bus_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_dev_bus_arbiter;

    localparam int unsigned W = 1;
    localparam logic [31:0] MAP_LO = 32'h0000_7F00;
    localparam logic [31:0] MAP_HI = 32'h0000_7F2F;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] br_addr, br_wdata, br_rdata;
    logic        br_we, busy, owner;

    bit          rd_fixed_en;
    logic [31:0] rd_fixed;

    int tests_run;
    int tests_failed;

    dev_bus_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_we    (m0_we),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m0_err   (m0_err),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_we    (m1_we),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .m1_err   (m1_err),
        .br_addr  (br_addr),
        .br_wdata (br_wdata),
        .br_we    (br_we),
        .br_rdata (br_rdata),
        .busy     (busy),
        .owner    (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bridge stand-in: either a forced value or a scramble of the presented address.
    function automatic logic [31:0] rd_func(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
    endfunction

    assign br_rdata = rd_fixed_en ? rd_fixed : rd_func(br_addr);

    function automatic logic [159:0] outvec();
        return {25'd0, busy, owner, br_we, br_addr, br_wdata,
                m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata};
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit m, input logic r, input logic [31:0] a,
                         input logic w, input logic [31:0] d);
        if (m) begin
            m1_req = r; m1_addr = a; m1_we = w; m1_wdata = d;
        end else begin
            m0_req = r; m0_addr = a; m0_we = w; m0_wdata = d;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one uncontended transaction from an IDLE negedge and returns what was observed;
    // ends on the IDLE negedge after the ack.
    task automatic single_txn(input bit m, input logic [31:0] addr, input logic we,
                              input logic [31:0] wdata, input logic [31:0] rd_in,
                              output int lat, output int pulses,
                              output logic [31:0] we_addr, output logic [31:0] we_data,
                              output logic [31:0] rdata, output logic err,
                              output int other_ack, output int acks, output int addr_cycles);
        lat = 0; pulses = 0; we_addr = '0; we_data = '0; rdata = '0; err = 1'b0;
        other_ack = 0; acks = 0; addr_cycles = 0;
        rd_fixed = rd_in;
        rd_fixed_en = 1'b1;
        drive(m, 1'b1, addr, we, wdata);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (br_we) begin
                pulses++;
                we_addr = br_addr;
                we_data = br_wdata;
            end
            if (busy && br_addr == addr) addr_cycles++;
            if (m ? m1_ack : m0_ack) begin
                acks++;
                if (lat == 0) begin
                    lat   = c;
                    rdata = m ? m1_rdata : m0_rdata;
                    err   = m ? m1_err : m0_err;
                end
                drive(m, 1'b0, addr, we, wdata);
            end
            if (m ? m0_ack : m1_ack) other_ack++;
            if (lat != 0 && c > lat) break;
        end
        drive(m, 1'b0, '0, 1'b0, '0);
    endtask

    typedef struct {
        bit          m;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rd_in;
        int          exp_pulses;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        bit          own;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        bit          hit;
        int          s;
        int          r;
    } txn_t;

    vec_t vecs[8];

    initial begin
        int lat, pulses, other_ack, acks, addr_cycles;
        logic [31:0] we_addr, we_data, rdata;
        logic err;
        int exp_order[4];
        int grants[4];
        int n, bad, cnt_ack, cnt_we, cnt_other;
        bit granted;

        tests_run = 0;
        tests_failed = 0;
        rd_fixed_en = 1'b1;
        rd_fixed = '0;

        vecs[0] = '{1'b0, 32'h0000_7F20, 1'b0, 32'h0,         32'hA5A5_0001, 0, 32'hA5A5_0001, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_7F14, 1'b1, 32'hDEAD_BEEF, 32'h0,         1, 32'h0,         1'b0};
        vecs[2] = '{1'b0, 32'h0000_1000, 1'b1, 32'h5555_AAAA, 32'hFFFF_FFFF, 0, 32'h0,         1'b1};
        vecs[3] = '{1'b1, 32'h0000_7F00, 1'b0, 32'h0,         32'h1234_0000, 0, 32'h1234_0000, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_7F2F, 1'b0, 32'h0,         32'h0000_2F2F, 0, 32'h0000_2F2F, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_7F30, 1'b0, 32'h0,         32'h7777_7777, 0, 32'h0,         1'b1};
        vecs[6] = '{1'b0, 32'h0000_7EFF, 1'b1, 32'h0BAD_0BAD, 32'h0,         0, 32'h0,         1'b1};
        vecs[7] = '{1'b0, 32'h0000_7F0F, 1'b1, 32'h0000_00C3, 32'h0,         1, 32'h0,         1'b0};

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        repeat (2) @(negedge clk);
        check("reset_busy", {159'd0, busy}, 160'd0);
        check("reset_outputs", outvec(), 160'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", outvec(), 160'd0);

        // Directed vector table
        foreach (vecs[i]) begin
            single_txn(vecs[i].m, vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].rd_in,
                       lat, pulses, we_addr, we_data, rdata, err, other_ack, acks, addr_cycles);
            check($sformatf("vec%0d_latency", i), 160'(lat), 160'(W + 2));
            check($sformatf("vec%0d_we_pulses", i), 160'(pulses), 160'(vecs[i].exp_pulses));
            if (vecs[i].exp_pulses == 1) begin
                check($sformatf("vec%0d_we_addr", i), 160'(we_addr), 160'(vecs[i].addr));
                check($sformatf("vec%0d_we_data", i), 160'(we_data), 160'(vecs[i].wdata));
            end
            check($sformatf("vec%0d_rdata", i), 160'(rdata), 160'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_err", i), 160'(err), 160'(vecs[i].exp_err));
            check($sformatf("vec%0d_other_ack", i), 160'(other_ack), 160'd0);
            check($sformatf("vec%0d_ack_count", i), 160'(acks), 160'd1);
            check($sformatf("vec%0d_addr_cycles", i), 160'(addr_cycles), 160'(W + 1));
        end

        // m1 drops req right after being granted; the transaction still completes
        rd_fixed_en = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_7F24, 1'b0, '0);
        granted = 1'b0;
        cnt_ack = 0;
        cnt_other = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (m1_ack) cnt_ack++;
            if (m0_ack) cnt_other++;
            if (!granted && busy && owner) begin
                granted = 1'b1;
                drive(1'b1, 1'b0, '0, 1'b0, '0);
            end
        end
        check("drop_granted", 160'(granted), 160'd1);
        check("drop_m1_ack_once", 160'(cnt_ack), 160'd1);
        check("drop_no_m0_ack", 160'(cnt_other), 160'd0);
        single_txn(1'b0, 32'h0000_7F18, 1'b0, '0, 32'h600D_0001,
                   lat, pulses, we_addr, we_data, rdata, err, other_ack, acks, addr_cycles);
        check("after_drop_latency", 160'(lat), 160'(W + 2));
        check("after_drop_rdata", 160'(rdata), 160'h600D_0001);

        // Reset during ACCESS of a write aborts it
        drive(1'b0, 1'b1, 32'h0000_7F10, 1'b1, 32'h1234_5678);
        @(negedge clk);
        check("abort_pre_busy", {159'd0, busy}, 160'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {159'd0, busy}, 160'd0);
        check("abort_outputs", outvec(), 160'd0);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt_we = 0;
        cnt_ack = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (br_we) cnt_we++;
            if (m0_ack || m1_ack) cnt_ack++;
        end
        check("abort_no_we", 160'(cnt_we), 160'd0);
        check("abort_no_ack", 160'(cnt_ack), 160'd0);
        single_txn(1'b1, 32'h0000_7F08, 1'b0, '0, 32'h0BAD_F00D,
                   lat, pulses, we_addr, we_data, rdata, err, other_ack, acks, addr_cycles);
        check("post_abort_latency", 160'(lat), 160'(W + 2));
        check("post_abort_rdata", 160'(rdata), 160'h0BAD_F00D);
        check("post_abort_acks", 160'(acks), 160'd1);

        // Both masters requesting continuously
        do_reset();
`ifdef ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        rd_fixed_en = 1'b0;
        drive(1'b0, 1'b1, 32'h0000_7F20, 1'b0, '0);
        drive(1'b1, 1'b1, 32'h0000_7F04, 1'b0, '0);
        n = 0;
        bad = 0;
        grants = '{-1, -1, -1, -1};
        for (int c = 0; c < 80 && n < 4; c++) begin
            @(negedge clk);
            if (m0_ack && m1_ack) bad++;
            if (m0_ack) begin
                grants[n] = 0;
                if (m1_rdata != 0 || m1_err) bad++;
                if (m0_rdata != rd_func(32'h0000_7F20) || m0_err) bad++;
                n++;
            end else if (m1_ack) begin
                grants[n] = 1;
                if (m0_rdata != 0 || m0_err) bad++;
                if (m1_rdata != rd_func(32'h0000_7F04) || m1_err) bad++;
                n++;
            end
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        check("rr_grant_count", 160'(n), 160'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_grant%0d", i), 160'(grants[i]), 160'(exp_order[i]));
        check("rr_port_isolation", 160'(bad), 160'd0);
        @(negedge clk);

        // Randomized run against the transaction-level model
        begin
            txn_t cur;
            bit   active;
            bit   last;
            int   cyc;
            int   st[2];
            logic [159:0] exp;
            bit   in_t, acc, resp;
            logic [31:0] exp_rd, a;

            do_reset();
            rd_fixed_en = 1'b0;
            active = 1'b0;
            last = 1'b1;
            cyc = 0;
            st = '{0, 0};
            cur = '{1'b0, '0, 1'b0, '0, 1'b0, 0, 0};
            for (int k = 0; k < 3000; k++) begin
                @(negedge clk);
                cyc++;
                in_t   = active && cyc >= cur.s && cyc <= cur.r;
                acc    = in_t && cyc < cur.r;
                resp   = in_t && cyc == cur.r;
                exp_rd = cur.hit ? rd_func(cur.addr) : 32'h0;
                exp = {25'd0, in_t, in_t & cur.own,
                       in_t && cyc == cur.r - 1 && cur.we && cur.hit,
                       acc ? cur.addr : 32'h0, acc ? cur.wdata : 32'h0,
                       resp && !cur.own, resp && !cur.own && !cur.hit,
                       (resp && !cur.own) ? exp_rd : 32'h0,
                       resp && cur.own, resp && cur.own && !cur.hit,
                       (resp && cur.own) ? exp_rd : 32'h0};
                check($sformatf("rand_cyc%0d", cyc), outvec(), exp);

                for (int m = 0; m < 2; m++) begin
                    if (m == 0 ? m0_ack : m1_ack) begin
                        st[m] = 0;
                        drive(m[0], 1'b0, '0, 1'b0, '0);
                    end else if (st[m] == 1 && busy && owner == m[0] && $urandom_range(0, 7) == 0) begin
                        st[m] = 2;
                        drive(m[0], 1'b0, '0, 1'b0, '0);
                    end
                    if (st[m] == 0 && $urandom_range(0, 2) == 0) begin
                        case ($urandom_range(0, 4))
                            0, 1, 2: a = MAP_LO + 32'($urandom_range(0, 47));
                            3: begin
                                case ($urandom_range(0, 3))
                                    0: a = MAP_LO - 1;
                                    1: a = MAP_LO;
                                    2: a = MAP_HI;
                                    default: a = MAP_HI + 1;
                                endcase
                            end
                            default: a = $urandom;
                        endcase
                        st[m] = 1;
                        drive(m[0], 1'b1, a, 1'($urandom_range(0, 1)), $urandom);
                    end
                end

                if ((!active || cyc > cur.r) && (m0_req || m1_req)) begin
`ifdef ARB_FIXED_PRIO_EN
                    cur.own = (m0_req && m1_req) ? 1'b0 : m1_req;
`else
                    cur.own = (m0_req && m1_req) ? ~last : m1_req;
`endif
                    cur.addr  = cur.own ? m1_addr  : m0_addr;
                    cur.we    = cur.own ? m1_we    : m0_we;
                    cur.wdata = cur.own ? m1_wdata : m0_wdata;
                    cur.hit   = (cur.addr >= MAP_LO) && (cur.addr <= MAP_HI);
                    cur.s     = cyc + 1;
                    cur.r     = cyc + int'(W) + 2;
                    last      = cur.own;
                    active    = 1'b1;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dev_bus_arbiter.md
Name: dev_bus_arbiter

Overview:
- Two-master arbiter and sequencer in front of the I/O bridge of the MIPS micro-system.
- Shares the single device bus between master 0 (CPU) and master 1 (DMA/debug loader), one transaction at a time.
- Decoded devices: timer/counter 0x7F00-0x7F0F, output 0x7F10-0x7F1F, input 0x7F20-0x7F2F.
- Adds programmable wait states, single-pulse device writes and address-miss error reporting.

Parameters:
- WAIT_CYCLES, 1, extra ACCESS cycles before sampling br_rdata; legal range 0..15.
- DEV_BASE, 32'h0000_7F00, lowest decoded device address.
- DEV_LIMIT, 32'h0000_7F2F, highest decoded device address (inclusive).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 request; held until m0_ack.
- m0_addr  in  32  master 0 byte address.
- m0_we  in  1  master 0 write enable.
- m0_wdata  in  32  master 0 write data.
- m0_ack  out  1  one-cycle completion pulse to master 0.
- m0_rdata  out  32  read data; valid while m0_ack is high.
- m0_err  out  1  address miss; valid while m0_ack is high.
- m1_req, m1_addr, m1_we, m1_wdata, m1_ack, m1_rdata, m1_err: same as m0_*, for master 1.
- br_addr  out  32  address to bridge praddr.
- br_wdata  out  32  write data to bridge wdin.
- br_we  out  1  write strobe to bridge wecpu.
- br_rdata  in  32  combinational read data from bridge rd.
- busy  out  1  high in every state except IDLE.
- owner  out  1  index of the master currently served; 0 in IDLE.

Behaviour:
- Reset: state=IDLE, last=1, cnt=0. All outputs are 0. Reset asserted mid-transaction aborts it: no ack and no br_we is ever issued for that transaction.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If any req is high, pick a winner. A sole requester wins; on a tie the master != last wins.
  - Latch addr, we and wdata into internal registers. Set owner=winner, cnt=WAIT_CYCLES, hit = (DEV_BASE <= addr <= DEV_LIMIT). Go to ACCESS.
- ACCESS:
  - br_addr and br_wdata come from the latched registers and stay stable for the whole state.
  - When cnt != 0: decrement cnt and stay.
  - When cnt == 0: br_we = latched we & hit for this one cycle only. Capture rdata = hit ? br_rdata : 0 and err = ~hit. Go to RESP.
- RESP:
  - Assert owner's ack for exactly one cycle, with rdata/err driven on the owner's ports only. The other master's outputs stay 0.
  - Set last=owner. Go to IDLE.
- Latency: req sampled in IDLE at cycle N gives ack in cycle N+WAIT_CYCLES+2. At WAIT_CYCLES=0 that is N+2.
- A mandatory IDLE cycle separates transactions, so peak throughput is one per WAIT_CYCLES+3 cycles.
- req dropped mid-transaction: the transaction still completes, br_we fires if due, and ack is still pulsed. Arbiter state is unaffected.
- Request inputs changing after the IDLE latch are ignored until the next IDLE.
- Both masters requesting continuously: grants alternate 0,1,0,1… starting with 0 after reset.
- Miss address: no br_we, rdata=0, err=1. Arbitration continues normally.
- br_addr and br_wdata are 0 in IDLE and RESP. br_we is 0 except during the single write cycle.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: master 0 always wins a tie and last is not used, so master 1 may starve.
- Undefined: round-robin as above.
- Latency and handshake are identical in both builds.

Decomposition:
- Package dev_bus_pkg holds:
  - the state enum {IDLE, ACCESS, RESP};
  - constants DEV_BASE, DEV_LIMIT and address-map constants TC_BASE=0x7F00, OUT_BASE=0x7F10, IN_BASE=0x7F20;
  - a function dev_hit(addr).
- One sub-module: rr_pick2. It is purely combinational: inputs req[1:0] and last; outputs valid and idx. It contains the ARB_FIXED_PRIO_EN switch.

Test Plan:
- Reset then m0 reads 0x7F20 with br_rdata=0xA5A5_0001, WAIT_CYCLES=1 -> br_addr=0x7F20 for 2 cycles, m0_ack pulse at N+3, m0_rdata=0xA5A5_0001, m0_err=0.
- m1 writes 0xDEAD_BEEF to 0x7F14 -> br_we high for exactly one cycle with br_addr=0x7F14 and br_wdata=0xDEAD_BEEF; m1_ack one cycle later.
- m0 and m1 both hold req for 4 transactions -> grant order 0,1,0,1, each ack on the correct port only. With ARB_FIXED_PRIO_EN the order is 0,0,0,0.
- m0 writes 0x0000_1000 -> br_we never asserts, m0_ack with m0_err=1 and m0_rdata=0.
- rst_n pulled low during ACCESS of a write -> busy=0 and all outputs 0 immediately; no br_we and no ack afterwards; a new request after rst_n rises is served normally.
- m1 drops req one cycle after grant -> m1_ack still pulses once and the next m0 request is granted normally.
